// File: rtl/t1_reg_slave.sv
// ---------------------------------------------------------------------------
// t1_reg_slave
//
// Register slave for the 100BASE-T1 DUT side of the cmd register bus. It
// decodes cmd/cmd_addr, holds the control, status, interrupt and scratch
// registers, and returns read data one cycle after a READ. It also contains
// the local-receiver-status qualifier. The qualifier only changes
// loc_rcvr_status after rx_lock has stayed at its new level for a
// programmable number of clk cycles.
//
// Ports
//   clk             : single clock, all state on posedge
//   rstn            : asynchronous active-low reset
//   cmd[1:0]        : 00 IDLE, 01 READ, 10 WRITE, 11 ignored (IDLE)
//   cmd_addr[7:0]   : byte address of the register
//   cmd_data_m2s    : write data
//   cmd_data_s2m    : read data, registered, held until the next READ
//   loc_low_timer   : cycles rx_lock must stay low before status drops
//   loc_high_timer  : cycles rx_lock must stay high before status rises
//   rx_lock         : PCS receiver lock indication
//   loc_rcvr_status : qualified local receiver status
//   irq             : level interrupt, registered
//
// Bus handshake: there is no valid/ready pair. cmd != IDLE is an implicit
// valid, and the slave is always ready. A WRITE updates the target register
// on the edge that samples it. A READ loads cmd_data_s2m on the edge that
// samples it, so the data is visible during the following cycle. A command
// may be issued every cycle.
//
// The FSM state is visible as a debug field in STATUS[2:1].
// ---------------------------------------------------------------------------
module t1_reg_slave #(
  parameter int          CNT_W       = 32,
  parameter int          LOCK_CNT_W  = 16,
  parameter logic [31:0] SCRATCH_RST = 32'h0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       cmd,
  input  logic [7:0]       cmd_addr,
  input  logic [31:0]      cmd_data_m2s,
  output logic [31:0]      cmd_data_s2m,
  input  logic [CNT_W-1:0] loc_low_timer,
  input  logic [CNT_W-1:0] loc_high_timer,
  input  logic             rx_lock,
  output logic             loc_rcvr_status,
  output logic             irq
);

  typedef enum logic [1:0] {
    NOT_OK    = 2'd0,
    QUAL_OK   = 2'd1,
    OK        = 2'd2,
    QUAL_FAIL = 2'd3
  } state_e;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_STATUS   = 8'h04;
  localparam logic [7:0] ADDR_LOW_TMR  = 8'h08;
  localparam logic [7:0] ADDR_HIGH_TMR = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h10;
  localparam logic [7:0] ADDR_LOCK_CNT = 8'h14;
  localparam logic [7:0] ADDR_SCRATCH  = 8'h18;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // State registers
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      thr_q, thr_d;        // frozen threshold, never 0
  logic [CNT_W-1:0]      low_tmr_q, low_tmr_d;
  logic [CNT_W-1:0]      high_tmr_q, high_tmr_d;
  logic                  status_q, status_d;
  logic [1:0]            ctrl_q, ctrl_d;      // [0] en, [1] irq_en
  logic [1:0]            irq_stat_q, irq_stat_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [31:0]           scratch_q, scratch_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic wr_en, rd_en, soft_rst, rise_evt, fall_evt;
  logic [1:0] w1c_mask;

  assign wr_en = (cmd == 2'b10);
  assign rd_en = (cmd == 2'b01);

  // soft_rst is never stored. It acts on the edge that samples the write,
  // so the CTRL register only ever holds en and irq_en.
  assign soft_rst = wr_en && (cmd_addr == ADDR_CTRL) && cmd_data_m2s[2];

  // Qualifier FSM, next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    thr_d      = thr_q;
    low_tmr_d  = low_tmr_q;
    high_tmr_d = high_tmr_q;
    status_d   = status_q;
    rise_evt   = 1'b0;
    fall_evt   = 1'b0;

    if (!ctrl_q[0] || soft_rst) begin
      // Forced drop: no event is raised, so no IRQ and no LOCK_CNT change.
      state_d  = NOT_OK;
      cnt_d    = '0;
      status_d = 1'b0;
    end else begin
      unique case (state_q)
        NOT_OK: begin
          if (rx_lock) begin
            state_d    = QUAL_OK;
            cnt_d      = '0;
            high_tmr_d = loc_high_timer;
            thr_d      = (loc_high_timer == '0) ? CNT_ONE : loc_high_timer;
          end
        end
        QUAL_OK: begin
          if (!rx_lock) begin
            state_d = NOT_OK;
          end else if (cnt_q == thr_q - CNT_ONE) begin
            state_d  = OK;
            status_d = 1'b1;
            rise_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        OK: begin
          if (!rx_lock) begin
            state_d   = QUAL_FAIL;
            cnt_d     = '0;
            low_tmr_d = loc_low_timer;
            thr_d     = (loc_low_timer == '0) ? CNT_ONE : loc_low_timer;
          end
        end
        QUAL_FAIL: begin
          if (rx_lock) begin
            state_d = OK;
          end else if (cnt_q == thr_q - CNT_ONE) begin
            state_d  = NOT_OK;
            status_d = 1'b0;
            fall_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = NOT_OK;
      endcase
    end
  end

  // Register file, next-state logic
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    w1c_mask  = 2'b00;
    rdata_d   = rdata_q;

    if (wr_en) begin
      unique case (cmd_addr)
        ADDR_CTRL:     ctrl_d    = cmd_data_m2s[1:0];
        ADDR_IRQ_STAT: w1c_mask  = cmd_data_m2s[1:0];
        ADDR_SCRATCH:  scratch_d = cmd_data_m2s;
        default:       ;
      endcase
    end

    // A new event takes priority over a W1C that hits the same bit.
    irq_stat_d = (irq_stat_q & ~w1c_mask) | {fall_evt, rise_evt};

    if ((rise_evt || fall_evt) && (lock_cnt_q != '1)) begin
      lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
    end else begin
      lock_cnt_d = lock_cnt_q;
    end

    if (rd_en) begin
      unique case (cmd_addr)
        ADDR_CTRL:     rdata_d = {30'd0, ctrl_q};
        ADDR_STATUS:   rdata_d = {29'd0, state_q, status_q};
        ADDR_LOW_TMR:  rdata_d = 32'(low_tmr_q);
        ADDR_HIGH_TMR: rdata_d = 32'(high_tmr_q);
        ADDR_IRQ_STAT: rdata_d = {30'd0, irq_stat_q};
        ADDR_LOCK_CNT: rdata_d = 32'(lock_cnt_q);
        ADDR_SCRATCH:  rdata_d = scratch_q;
        default:       rdata_d = 32'd0;
      endcase
    end

    irq_d = ctrl_q[1] & (|irq_stat_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= NOT_OK;
      cnt_q      <= '0;
      thr_q      <= CNT_ONE;
      low_tmr_q  <= '0;
      high_tmr_q <= '0;
      status_q   <= 1'b0;
      ctrl_q     <= 2'b00;
      irq_stat_q <= 2'b00;
      lock_cnt_q <= '0;
      scratch_q  <= SCRATCH_RST;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      thr_q      <= thr_d;
      low_tmr_q  <= low_tmr_d;
      high_tmr_q <= high_tmr_d;
      status_q   <= status_d;
      ctrl_q     <= ctrl_d;
      irq_stat_q <= irq_stat_d;
      lock_cnt_q <= lock_cnt_d;
      scratch_q  <= scratch_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign cmd_data_s2m    = rdata_q;
  assign loc_rcvr_status = status_q;
  assign irq             = irq_q;

endmodule
